// File: rtl/display_mux_7seg_ndigit_pkg.sv
// Shared segment patterns and counter-width helper for the multiplexed 7-segment driver.
// Patterns are active-high, bit order {g,f,e,d,c,b,a}.
package display_pkg;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Bits needed to hold 0..n-1, never less than 1.
    function automatic int unsigned cnt_width(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((64'd1 << w) < 64'(n)) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/display_mux_7seg_ndigit_decoder.sv
// Combinational BCD to 7-segment decoder, active-high; codes 10-15 render as a dash.
module bcd_to_seg7_decoder
    import display_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/display_mux_7seg_ndigit.sv
// Multiplexed N-digit 7-segment driver with refresh prescaler, frame-synchronous input capture,
// leading-zero blanking and per-digit DP. Optional blinking under DISPLAY_BLINK_EN.
module display_mux_7seg_ndigit
    import display_pkg::*;
#(
    parameter int unsigned NUM_DIGITS  = 4,
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned ACTIVE_LOW  = 1
`ifdef DISPLAY_BLINK_EN
    ,
    parameter int unsigned BLINK_FRAMES = 250
`endif
)
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] bcd,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    blank_lz,
`ifdef DISPLAY_BLINK_EN
    input  logic [NUM_DIGITS-1:0]   blink_mask,
`endif
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic                    DP,
    output logic                    frame_done
);

    localparam int unsigned PRESC_W = cnt_width(REFRESH_DIV);
    localparam int unsigned IDX_W   = cnt_width(NUM_DIGITS);
    localparam logic        POL     = (ACTIVE_LOW != 0);

    logic [PRESC_W-1:0]      presc_q, presc_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    first_q;
    logic [4*NUM_DIGITS-1:0] bcd_q, bcd_v;
    logic [NUM_DIGITS-1:0]   dp_q, dp_v;
    logic                    blank_q, blank_v;

    logic tick, idx_last, frame_wrap, capture;

    logic [3:0]            cur_digit;
    logic                  cur_dp, cur_blank, upper_zero;
    logic [NUM_DIGITS-1:0] sel_raw;
    logic [6:0]            dec_seg, seg_raw;
    logic                  dp_raw;

    logic [6:0]            seg_q;
    logic [NUM_DIGITS-1:0] sel_q;
    logic                  dp_out_q, frame_done_q;

`ifdef DISPLAY_BLINK_EN
    localparam int unsigned FRM_W = cnt_width(BLINK_FRAMES);
    logic [NUM_DIGITS-1:0] mask_q, mask_v;
    logic [FRM_W-1:0]      frm_cnt_q, frm_cnt_d;
    logic                  phase_q, phase_d;
    logic                  cur_mask;
`endif

    always_comb begin
        tick       = (presc_q == PRESC_W'(REFRESH_DIV - 1));
        idx_last   = (idx_q == IDX_W'(NUM_DIGITS - 1));
        frame_wrap = tick & idx_last;
        capture    = first_q | frame_wrap;
        presc_d    = tick ? '0 : presc_q + PRESC_W'(1);
        idx_d      = idx_q;
        if (tick) begin
            idx_d = idx_last ? '0 : idx_q + IDX_W'(1);
        end
    end

    // The very first frame after reset shows the live inputs, not the cleared shadows.
    always_comb begin
        bcd_v   = first_q ? bcd : bcd_q;
        dp_v    = first_q ? dp_in : dp_q;
        blank_v = first_q ? blank_lz : blank_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q <= '0;
            idx_q   <= '0;
            first_q <= 1'b1;
            bcd_q   <= '0;
            dp_q    <= '0;
            blank_q <= 1'b0;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            first_q <= 1'b0;
            if (capture) begin
                bcd_q   <= bcd;
                dp_q    <= dp_in;
                blank_q <= blank_lz;
            end
        end
    end

    // Scan from the top digit down so upper_zero covers this digit and all above it.
    always_comb begin
        cur_digit  = 4'd0;
        cur_dp     = 1'b0;
        cur_blank  = 1'b0;
        sel_raw    = '0;
        upper_zero = 1'b1;
        for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
            upper_zero = upper_zero & (bcd_v[4*i +: 4] == 4'd0);
            if (idx_q == IDX_W'(i)) begin
                cur_digit  = bcd_v[4*i +: 4];
                cur_dp     = dp_v[i];
                cur_blank  = blank_v & upper_zero & (i != 0);
                sel_raw[i] = 1'b1;
            end
        end
    end

    bcd_to_seg7_decoder u_decoder (
        .bcd (cur_digit),
        .seg (dec_seg)
    );

`ifdef DISPLAY_BLINK_EN
    always_comb begin
        mask_v   = first_q ? blink_mask : mask_q;
        cur_mask = 1'b0;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_mask = mask_v[i];
            end
        end
        frm_cnt_d = frm_cnt_q;
        phase_d   = phase_q;
        if (frame_wrap) begin
            if (frm_cnt_q == FRM_W'(BLINK_FRAMES - 1)) begin
                frm_cnt_d = '0;
                phase_d   = ~phase_q;
            end else begin
                frm_cnt_d = frm_cnt_q + FRM_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask_q    <= '0;
            frm_cnt_q <= '0;
            phase_q   <= 1'b0;
        end else begin
            frm_cnt_q <= frm_cnt_d;
            phase_q   <= phase_d;
            if (capture) begin
                mask_q <= blink_mask;
            end
        end
    end
`endif

    always_comb begin
        seg_raw = cur_blank ? SEG_BLANK : dec_seg;
        dp_raw  = cur_dp;
`ifdef DISPLAY_BLINK_EN
        if (phase_q & cur_mask) begin
            seg_raw = SEG_BLANK;
            dp_raw  = 1'b0;
        end
`endif
    end

    // Polarity is applied at the output registers so reset lands on the inactive level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg_q        <= {7{POL}};
            sel_q        <= {NUM_DIGITS{POL}};
            dp_out_q     <= POL;
            frame_done_q <= 1'b0;
        end else begin
            seg_q        <= seg_raw ^ {7{POL}};
            sel_q        <= sel_raw ^ {NUM_DIGITS{POL}};
            dp_out_q     <= dp_raw ^ POL;
            frame_done_q <= frame_wrap;
        end
    end

    assign seg        = seg_q;
    assign digit_sel  = sel_q;
    assign DP         = dp_out_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_display_mux_7seg_ndigit.sv
// Directed bench for display_mux_7seg_ndigit: NUM_DIGITS=4, REFRESH_DIV=4, ACTIVE_LOW=1.
module tb_display_mux_7seg_ndigit;

    logic        clk;
    logic        reset;
    logic [15:0] bcd;
    logic [3:0]  dp_in;
    logic        blank_lz;
`ifdef DISPLAY_BLINK_EN
    logic [3:0]  blink_mask;
`endif
    logic [6:0]  seg;
    logic [3:0]  digit_sel;
    logic        DP;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    display_mux_7seg_ndigit #(
        .NUM_DIGITS  (4),
        .REFRESH_DIV (4),
        .ACTIVE_LOW  (1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bcd        (bcd),
        .dp_in      (dp_in),
        .blank_lz   (blank_lz),
`ifdef DISPLAY_BLINK_EN
        .blink_mask (blink_mask),
`endif
        .seg        (seg),
        .digit_sel  (digit_sel),
        .DP         (DP),
        .frame_done (frame_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Per-slot expected pin levels (active-low), packed {slot3, slot2, slot1, slot0}.
    typedef struct packed {
        logic [15:0] bcd;
        logic [3:0]  dp;
        logic        blz;
        logic [27:0] segs;
        logic [3:0]  edp;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic check_slot(input string tag, input int s, input logic [6:0] es,
                              input logic edp);
        logic [3:0] one;
        one = 4'b0001;
        chk({tag, " digit_sel"}, 32'(digit_sel), 32'(4'hF ^ (one << s)));
        chk({tag, " seg"}, 32'(seg), 32'(es));
        chk({tag, " DP"}, 32'(DP), 32'(edp));
    endtask

    task automatic check_inactive(input string tag);
        chk({tag, " seg"}, 32'(seg), 32'h7F);
        chk({tag, " digit_sel"}, 32'(digit_sel), 32'hF);
        chk({tag, " DP"}, 32'(DP), 32'h1);
        chk({tag, " frame_done"}, 32'(frame_done), 32'h0);
    endtask

    // Hold reset for two cycles, check the idle pins, release on a falling edge.
    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_inactive("reset");
        reset = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    localparam logic [27:0] SEGS_1234 = {7'h79, 7'h24, 7'h30, 7'h19};
    localparam logic [27:0] SEGS_5678 = {7'h12, 7'h02, 7'h78, 7'h00};

    initial begin
        logic [27:0] segs;
        int          s;

        reset    = 1'b1;
        bcd      = 16'h0000;
        dp_in    = 4'h0;
        blank_lz = 1'b0;
`ifdef DISPLAY_BLINK_EN
        blink_mask = 4'h0;
`endif

        vecs[0] = '{bcd: 16'h1234, dp: 4'h0, blz: 1'b0, segs: SEGS_1234, edp: 4'hF};
        vecs[1] = '{bcd: 16'h0007, dp: 4'h0, blz: 1'b1,
                    segs: {7'h7F, 7'h7F, 7'h7F, 7'h78}, edp: 4'hF};
        vecs[2] = '{bcd: 16'h0000, dp: 4'h0, blz: 1'b1,
                    segs: {7'h7F, 7'h7F, 7'h7F, 7'h40}, edp: 4'hF};
        vecs[3] = '{bcd: 16'hA0F9, dp: 4'h0, blz: 1'b0,
                    segs: {7'h3F, 7'h40, 7'h3F, 7'h10}, edp: 4'hF};
        vecs[4] = '{bcd: 16'h0012, dp: 4'b0100, blz: 1'b1,
                    segs: {7'h7F, 7'h7F, 7'h79, 7'h24}, edp: 4'b1011};
        vecs[5] = '{bcd: 16'h0900, dp: 4'h0, blz: 1'b1,
                    segs: {7'h7F, 7'h10, 7'h40, 7'h40}, edp: 4'hF};
        vecs[6] = '{bcd: 16'h5678, dp: 4'hF, blz: 1'b0, segs: SEGS_5678, edp: 4'h0};
        vecs[7] = '{bcd: 16'h0000, dp: 4'h0, blz: 1'b0,
                    segs: {7'h40, 7'h40, 7'h40, 7'h40}, edp: 4'hF};

        // Table: one full frame per vector straight out of reset.
        for (int v = 0; v < 8; v++) begin
            bcd      = vecs[v].bcd;
            dp_in    = vecs[v].dp;
            blank_lz = vecs[v].blz;
            do_reset();
            for (int k = 1; k <= 16; k++) begin
                step();
                s = (k - 1) / 4;
                segs = vecs[v].segs;
                check_slot($sformatf("vec%0d k%0d", v, k), s, segs[7*s +: 7], vecs[v].edp[s]);
            end
        end

        // Mid-frame input change must wait for the frame boundary.
        bcd      = 16'h1234;
        dp_in    = 4'h0;
        blank_lz = 1'b0;
        do_reset();
        for (int k = 1; k <= 32; k++) begin
            step();
            s = ((k - 1) / 4) % 4;
            segs = (k <= 16) ? SEGS_1234 : SEGS_5678;
            check_slot($sformatf("tear k%0d", k), s, segs[7*s +: 7], 1'b1);
            chk($sformatf("tear frame_done k%0d", k), 32'(frame_done),
                32'((k == 16) || (k == 32)));
            if (k == 6) bcd = 16'h5678;
        end

        // Asynchronous reset in the middle of the digit-2 slot.
        bcd = 16'h1234;
        do_reset();
        for (int k = 1; k <= 10; k++) step();
        check_slot("pre-async", 2, 7'h24, 1'b1);
        #1 reset = 1'b1;
        #1 check_inactive("async");
        @(negedge clk);
        check_inactive("async hold");
        reset = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            step();
            s = ((k - 1) / 4) % 4;
            check_slot($sformatf("restart k%0d", k), s, SEGS_1234[7*s +: 7], 1'b1);
            chk($sformatf("frame_done k%0d", k), 32'(frame_done), 32'((k % 16) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
